// File: rtl/a2d_sched.sv
// a2d_sched: round-robin + host-request channel scheduler for the shared ADC128S SPI engine
// ports: clk/rst; nxt, hreq, hreq_sel triggers; wrt/cmd/done/rd_data to the SPI engine;
//        lft_ld/rght_ld/steer_pot/batt latest results; vld/hack/busy status
module a2d_sched #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        hreq,
  input  logic [1:0]  hreq_sel,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic        hack,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2, UPD} state_t;
  state_t r_state, w_nxt;
  logic r_npend, r_hpend, r_host, r_wrt, r_vld, r_hack, r_busy;
  logic [1:0] r_hsel, r_ptr, r_slot, w_hsel, w_slot;
  logic [2:0] w_ch;
  logic [15:0] r_cmd;
  logic [11:0] r_lft, r_rght, r_steer, r_batt;
  logic w_idle, w_hp, w_np, w_hgnt, w_ngnt, w_upd, w_wrt, w_unused;

  always_ff @(posedge clk) r_state <= rst ? IDLE : w_nxt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = (w_hp || w_np) ? CMD : IDLE;
      CMD:     w_nxt = WAIT1;
      WAIT1:   w_nxt = done ? GAP : WAIT1;
      GAP:     w_nxt = READ;
      READ:    w_nxt = WAIT2;
      WAIT2:   w_nxt = done ? UPD : WAIT2;
      default: w_nxt = IDLE;
    endcase
  end

  // a trigger arriving in the same cycle as the IDLE decision is granted immediately
  always_comb begin
    w_idle = r_state == IDLE;
    w_hp   = r_hpend || hreq;
    w_np   = r_npend || nxt;
    w_hgnt = w_idle && w_hp;
    w_ngnt = w_idle && !w_hp && w_np;
    w_hsel = hreq ? hreq_sel : r_hsel;
    w_slot = w_hgnt ? w_hsel : r_ptr;
    w_ch   = (w_slot == 2'd0) ? CH_LFT : (w_slot == 2'd1) ? CH_RGHT :
             (w_slot == 2'd2) ? CH_STEER : CH_BATT;
    w_upd  = r_state == WAIT2 && done;
    w_wrt  = w_nxt == CMD || w_nxt == READ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_npend <= 1'b0;
      r_hpend <= 1'b0;
      r_hsel  <= 2'd0;
      r_host  <= 1'b0;
      r_slot  <= 2'd0;
      r_ptr   <= 2'd0;
      r_cmd   <= 16'h0000;
      r_wrt   <= 1'b0;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_hack  <= 1'b0;
      r_lft   <= 12'h000;
      r_rght  <= 12'h000;
      r_steer <= 12'h000;
      r_batt  <= 12'h000;
    end else begin
      r_npend <= w_np && !w_ngnt;
      r_hpend <= w_hp && !w_hgnt;
      r_hsel  <= w_hsel;
      r_wrt   <= w_wrt;
      r_busy  <= w_nxt != IDLE;
      r_vld   <= w_upd;
      r_hack  <= w_upd && r_host;
      if (w_hgnt || w_ngnt) begin
        r_slot <= w_slot;
        r_host <= w_hgnt;
        r_cmd  <= {2'b00, w_ch, 11'h000};
      end
      if (w_upd && !r_host) r_ptr <= r_ptr + 2'd1;
      r_lft   <= (w_upd && r_slot == 2'd0) ? rd_data[11:0] : r_lft;
      r_rght  <= (w_upd && r_slot == 2'd1) ? rd_data[11:0] : r_rght;
      r_steer <= (w_upd && r_slot == 2'd2) ? rd_data[11:0] : r_steer;
      r_batt  <= (w_upd && r_slot == 2'd3) ? rd_data[11:0] : r_batt;
    end
  end

  assign w_unused  = ^rd_data[15:12];
  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign lft_ld    = r_lft;
  assign rght_ld   = r_rght;
  assign steer_pot = r_steer;
  assign batt      = r_batt;
  assign vld       = r_vld;
  assign hack      = r_hack;
  assign busy      = r_busy;
endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: randomized directed bench for a2d_sched with SPI responder and slot-level reference model
module tb_a2d_sched;
  logic clk = 1'b0, rst = 1'b1, nxt = 1'b0, hreq = 1'b0;
  logic [1:0] hreq_sel = 2'd0;
  logic man_done = 1'b0, rsp_done = 1'b0;
  logic [15:0] man_data = 16'h0, rsp_data = 16'h0;
  logic done;
  logic [15:0] rd_data;
  logic wrt, vld, hack, busy;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  int total = 0, bad = 0;

  assign done    = man_done | rsp_done;
  assign rd_data = man_done ? man_data : rsp_data;

  always #5 clk = ~clk;

  a2d_sched dut (
    .clk(clk), .rst(rst), .nxt(nxt), .hreq(hreq), .hreq_sel(hreq_sel),
    .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .vld(vld), .hack(hack), .busy(busy)
  );

  localparam logic [15:0] CMDS [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};

  logic [15:0] obs_cmd[$], exp_cmd[$], rd_q[$];
  bit obs_hack[$], exp_hack[$];
  int n_vld = 0, n_wrt = 0, wrt_dbl = 0, exp_vld = 0, m_ptr = 0;
  logic prev_wrt = 1'b0;
  logic [11:0] exp_res [4];

  always @(negedge clk) begin
    if (wrt) begin
      obs_cmd.push_back(cmd);
      n_wrt++;
    end
    if (wrt && prev_wrt) wrt_dbl++;
    prev_wrt = wrt;
    if (vld) begin
      n_vld++;
      obs_hack.push_back(hack);
    end
  end

  bit spi_en = 1'b1, phase = 1'b0;
  int dly_min = 1;
  logic [15:0] rsp_d;
  always begin
    @(negedge clk);
    if (spi_en && wrt) begin
      phase = ~phase;
      rsp_d = (phase || rd_q.size() == 0) ? 16'($urandom) : rd_q.pop_front();
      repeat ($urandom_range(dly_min, dly_min + 3)) @(negedge clk);
      rsp_data = rsp_d;
      rsp_done = 1'b1;
      @(negedge clk);
      rsp_done = 1'b0;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_conv(int slot, bit host, logic [15:0] d);
    exp_cmd.push_back(CMDS[slot]);
    exp_cmd.push_back(CMDS[slot]);
    rd_q.push_back(d);
    exp_res[slot] = d[11:0];
    exp_vld++;
    exp_hack.push_back(host);
    if (!host) m_ptr = (m_ptr + 1) % 4;
  endtask

  task automatic model_rr(logic [15:0] d);
    model_conv(m_ptr, 1'b0, d);
  endtask

  task automatic wait_idle();
    int q = 0, n = 0;
    while (q < 3 && n < 400) begin
      @(negedge clk);
      q = busy ? 0 : q + 1;
      n++;
    end
    chk("idle_timeout", q, 3);
  endtask

  task automatic check_all(string tag);
    chk({tag, "_ncmd"}, obs_cmd.size(), exp_cmd.size());
    while (obs_cmd.size() != 0 && exp_cmd.size() != 0)
      chk({tag, "_cmd"}, obs_cmd.pop_front(), exp_cmd.pop_front());
    obs_cmd.delete();
    exp_cmd.delete();
    chk({tag, "_nhack"}, obs_hack.size(), exp_hack.size());
    while (obs_hack.size() != 0 && exp_hack.size() != 0)
      chk({tag, "_hack"}, obs_hack.pop_front(), exp_hack.pop_front());
    obs_hack.delete();
    exp_hack.delete();
    chk({tag, "_lft"}, lft_ld, exp_res[0]);
    chk({tag, "_rght"}, rght_ld, exp_res[1]);
    chk({tag, "_steer"}, steer_pot, exp_res[2]);
    chk({tag, "_batt"}, batt, exp_res[3]);
    chk({tag, "_nvld"}, n_vld, exp_vld);
    chk({tag, "_wrt_dbl"}, wrt_dbl, 0);
  endtask

  initial begin
    logic [15:0] tp [4];
    logic [15:0] d;
    int op, sel, base, seen, n;
    tp = '{16'h0ABC, 16'h0123, 16'h0456, 16'h0FFF};
    foreach (exp_res[i]) exp_res[i] = 12'h000;

    repeat (3) @(negedge clk);
    chk("rst_wrt", wrt, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_lft", lft_ld, 0);
    chk("rst_rght", rght_ld, 0);
    chk("rst_steer", steer_pot, 0);
    chk("rst_batt", batt, 0);
    chk("rst_vld", vld, 0);
    chk("rst_hack", hack, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      model_rr(tp[i]);
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
      if (i == 0) begin
        chk("lat_wrt", wrt, 1);
        chk("lat_cmd", cmd, 16'h0000);
        chk("lat_busy", busy, 1);
      end
      wait_idle();
    end
    check_all("rr4");

    model_rr(16'hF555);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    wait_idle();
    check_all("rr5");
    chk("lft_trunc", lft_ld, 12'h555);
    chk("wrt_pulses", n_wrt, 10);

    model_conv(3, 1'b1, 16'($urandom));
    model_rr(16'($urandom));
    hreq_sel = 2'd3;
    hreq = 1'b1;
    nxt = 1'b1;
    @(negedge clk);
    hreq = 1'b0;
    nxt = 1'b0;
    wait_idle();
    check_all("both");

    dly_min = 2;
    model_rr(16'($urandom));
    model_rr(16'($urandom));
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
      @(negedge clk);
    end
    wait_idle();
    check_all("absorb");

    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      dly_min = $urandom_range(1, 3);
      if (op != 0) model_conv(sel, 1'b1, 16'($urandom));
      if (op != 1) model_rr(16'($urandom));
      hreq_sel = 2'(sel);
      hreq = op != 0;
      nxt = op != 1;
      @(negedge clk);
      hreq = 1'b0;
      nxt = 1'b0;
      wait_idle();
    end
    check_all("rand");

    spi_en = 1'b0;
    man_data = 16'h0777;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_done_busy", busy, 0);
    check_all("idle_done");

    exp_cmd.push_back(CMDS[m_ptr]);
    exp_cmd.push_back(CMDS[m_ptr]);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    chk("gap_wrt1", wrt, 1);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    chk("gap_wrt0", wrt, 0);
    @(negedge clk);
    man_done = 1'b0;
    chk("gap_wrt2", wrt, 1);
    repeat (3) @(negedge clk);
    chk("gap_busy", busy, 1);
    chk("gap_novld", n_vld, exp_vld);
    d = 16'($urandom);
    man_data = d;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("gap_vld", vld, 1);
    exp_res[m_ptr] = d[11:0];
    exp_vld++;
    exp_hack.push_back(1'b0);
    m_ptr = (m_ptr + 1) % 4;
    wait_idle();
    check_all("gap");

    spi_en = 1'b1;
    dly_min = 4;
    exp_cmd.push_back(CMDS[m_ptr]);
    exp_cmd.push_back(CMDS[m_ptr]);
    rd_q.push_back(16'h0AAA);
    base = n_wrt;
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    seen = 1;
    n = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (wrt) seen++;
    end
    chk("abort_reach", seen, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_wrt", wrt, 0);
    chk("abort_busy", busy, 0);
    foreach (exp_res[i]) exp_res[i] = 12'h000;
    m_ptr = 0;
    repeat (10) @(negedge clk);
    chk("abort_busy2", busy, 0);
    chk("abort_nwrt", n_wrt, base + 2);
    check_all("abort");

    dly_min = 1;
    model_rr(16'($urandom));
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    wait_idle();
    check_all("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/a2d_sched.md
# a2d_sched

Channel scheduler for the shared A2D SPI transaction engine of the Segway controller. Sequences ADC128S conversions across the four analog inputs (left load cell, right load cell, steering pot, battery) in round-robin order, one conversion per trigger. Also grants out-of-turn single reads to a host requester. Holds the latest 12-bit result per channel for the balance, steering and battery-monitor logic.

## Interface
Parameters:
- `CH_LFT`, default 3'd0: ADC channel of the left load cell
- `CH_RGHT`, default 3'd4: ADC channel of the right load cell
- `CH_STEER`, default 3'd5: ADC channel of the steering pot
- `CH_BATT`, default 3'd6: ADC channel of the battery

Ports:
- `clk` in 1: system clock; the only clock
- `rst` in 1: reset, synchronous, active-high
- `nxt` in 1: round-robin trigger pulse, from inertial valid
- `hreq` in 1: host single-read request pulse
- `hreq_sel` in 2: host slot select, 0=lft, 1=rght, 2=steer, 3=batt
- `wrt` out 1: start pulse to the SPI engine
- `cmd` out 16: SPI command word
- `done` in 1: SPI transaction complete pulse
- `rd_data` in 16: SPI received word
- `lft_ld` out 12: latest left load-cell result
- `rght_ld` out 12: latest right load-cell result
- `steer_pot` out 12: latest steering result
- `batt` out 12: latest battery result
- `vld` out 1: one-cycle pulse when any result register updates
- `hack` out 1: one-cycle pulse when a host-requested result updates
- `busy` out 1: high whenever the state is not IDLE

## Operation
- Slot pointer `ptr` (2 bits) selects the round-robin slot, with the same mapping as `hreq_sel`.
- Pending flags:
  - `npend` is set by `nxt`.
  - `hpend` is set by `hreq`, and latches `hreq_sel` into `hsel`.
  - A second `hreq` while `hpend` is set overwrites `hsel`.
  - Each flag is one deep; extra triggers while set are absorbed.
- Arbitration happens in IDLE only. `hpend` has priority over `npend`.
  - Host grant: slot = `hsel`; clear `hpend`; `ptr` unchanged.
  - Round-robin grant: slot = `ptr`; clear `npend`.
- cmd = {2'b00, CH_x[2:0], 11'h000}. It is held constant for the whole conversion.
- States:
  - IDLE: if either flag is set (including one set this cycle), grant, then go to CMD.
  - CMD: `wrt`=1 for one cycle, then go to WAIT1.
  - WAIT1: on `done`, go to GAP. This transaction sets the channel address; its data is discarded.
  - GAP: one cycle, `wrt`=0, then go to READ.
  - READ: `wrt`=1 for one cycle, then go to WAIT2.
  - WAIT2: on `done`, go to UPD.
  - UPD: load `rd_data[11:0]` into the selected result register. Pulse `vld`. Pulse `hack` if the grant was host. On a round-robin grant, `ptr` <= `ptr`+1 (3 wraps to 0). Then go to IDLE.
- `done` outside WAIT1/WAIT2 is ignored.
- `nxt` or `hreq` arriving in any state only sets its flag. It is served on the next return to IDLE.
- `nxt` and `hreq` in the same cycle: both flags set; host served first, round-robin next.
- `rst` mid-conversion:
  - Next state is IDLE; `wrt` is 0 on the following cycle.
  - Flags cleared; `ptr`=0; all result registers = 0.
  - A later `done` from the aborted transaction is ignored.

## Timing
- Reset values: `wrt`=0, `cmd`=16'h0000, all results 12'h000, `vld`=0, `hack`=0, `busy`=0, state IDLE, `ptr`=0.
- All outputs are registered.
- `nxt` (or `hreq`) sampled high at edge t in IDLE: `cmd` valid and `wrt`=1 in cycle t+1.
- `done` at edge d1: `wrt`=1 for the second transaction two cycles later (after GAP).
- Second `done` at edge d2: result register and `vld` update at d2+1.
- Back-to-back: when a flag is pending at UPD, the next `wrt` follows 2 cycles after `vld`.
- `busy` is 1 from the cycle after grant through UPD, inclusive.

## Test plan
- Reset then four `nxt` pulses. SPI model returns 16'h0ABC, 0x123, 0x456, 0xFFF. Required:
  - cmd sequence 0x0000, 0x2000, 0x2800, 0x3000, each issued twice.
  - lft_ld=ABC, rght_ld=123, steer_pot=456, batt=FFF.
  - four `vld` pulses, `ptr` back at 0.
- Fifth `nxt` returns 0xF555. Required: lft_ld=555 (upper nibble dropped) and `wrt` high exactly one cycle per transaction.
- `hreq` with hreq_sel=3 and `nxt` in the same cycle, `ptr`=1. Required:
  - first conversion uses cmd 0x3000 and pulses `hack`;
  - second uses 0x2000 with no `hack`;
  - `ptr` ends at 2.
- Three `nxt` pulses during one conversion. Required: exactly one extra conversion follows.
- `rst` asserted in WAIT2, then a stray `done`. Required: all results 0, `wrt` stays 0, `busy`=0, no `vld`.
- `done` pulsed in IDLE and GAP. Required: no state change and no result update.
